// File: rtl/allbit_pkg.sv
// Shared types and default sizes for the all-bit scan controller.
package allbit_pkg;

   localparam int unsigned DefWidth = 32;
   localparam int unsigned DefAddrW = 8;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StDone
   } state_e;

endpackage

// File: rtl/allbit_scan_ctrl_if.sv
// Single-outstanding read port between the scan controller and word memory.
interface allbit_scan_ctrl_if
   import allbit_pkg::*;
#(
   parameter int unsigned WIDTH  = DefWidth,
   parameter int unsigned ADDR_W = DefAddrW
);

   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic [WIDTH-1:0]  rd_data;
   logic              rd_valid;

   modport master (
      output rd_req,
      output rd_addr,
      input  rd_data,
      input  rd_valid
   );

   modport slave (
      input  rd_req,
      input  rd_addr,
      output rd_data,
      output rd_valid
   );

endinterface

// File: rtl/allbit_detect.sv
// Combinational all-zero / all-one detector for one word.
module allbit_detect #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] x,
   output logic             zero,
   output logic             one
);

   assign zero = ~|x;
   assign one  = &x;

endmodule

// File: rtl/allbit_scan_ctrl.sv
// Scans len words from base_addr, one read at a time, and reports all-zero / all-one.
// Optional build macro ALLBIT_SCAN_EARLY_EXIT_EN stops once both flags are known false.
module allbit_scan_ctrl
   import allbit_pkg::*;
#(
   parameter int unsigned WIDTH  = DefWidth,
   parameter int unsigned ADDR_W = DefAddrW
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic              all_zero,
   output logic              all_one,
   allbit_scan_ctrl_if.master rd_bus
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [ADDR_W:0]   cnt_inc;
   logic              z_acc_q, z_acc_d;
   logic              o_acc_q, o_acc_d;
   logic              res_q, res_d;
   logic              word_zero, word_one;
   logic              z_upd, o_upd;
   logic              last_word;

   allbit_detect #(
      .WIDTH(WIDTH)
   ) u_detect (
      .x    (rd_bus.rd_data),
      .zero (word_zero),
      .one  (word_one)
   );

   assign z_upd   = z_acc_q & word_zero;
   assign o_upd   = o_acc_q & word_one;
   assign cnt_inc = cnt_q + (ADDR_W + 1)'(1);

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      z_acc_d   = z_acc_q;
      o_acc_d   = o_acc_q;
      res_d     = res_q;
      last_word = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               base_d  = base_addr;
               len_d   = len;
               cnt_d   = '0;
               z_acc_d = 1'b1;
               o_acc_d = 1'b1;
               // Results are withdrawn for the duration of the new scan.
               res_d   = 1'b0;
               if (len == '0) begin
                  state_d = StDone;
                  res_d   = 1'b1;
               end else begin
                  state_d = StReq;
               end
            end
         end
         StReq: state_d = StWait;
         StWait: begin
            if (rd_bus.rd_valid) begin
               z_acc_d   = z_upd;
               o_acc_d   = o_upd;
               cnt_d     = cnt_inc;
               last_word = (cnt_inc == len_q);
`ifdef ALLBIT_SCAN_EARLY_EXIT_EN
               if (!z_upd && !o_upd) begin
                  last_word = 1'b1;
               end
`endif
               if (last_word) begin
                  state_d = StDone;
                  res_d   = 1'b1;
               end else begin
                  state_d = StReq;
               end
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         base_q  <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
         z_acc_q <= 1'b0;
         o_acc_q <= 1'b0;
         res_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         z_acc_q <= z_acc_d;
         o_acc_q <= o_acc_d;
         res_q   <= res_d;
      end
   end

   assign busy           = (state_q == StReq) || (state_q == StWait);
   assign done           = (state_q == StDone);
   assign rd_bus.rd_req  = (state_q == StReq);
   assign rd_bus.rd_addr = base_q + cnt_q[ADDR_W-1:0];
   assign all_zero       = res_q & z_acc_q;
   assign all_one        = res_q & o_acc_q;

endmodule

// File: doc/allbit_scan_ctrl.md
Name: allbit_scan_ctrl

Overview:
- Sequential controller that scans a region of word memory and reports whether every word in it is all-zero and/or all-one.
- Issues one read at a time and feeds each returned word through a combinational all-bit detector.
- Accumulates the two flags and signals completion with a start/busy/done handshake.
- Used by memory-clear checks and self-test to verify a buffer after fill or scrub.

Parameters:
- WIDTH, 32, data word width in bits.
- ADDR_W, 8, word address width; also sets the maximum region size (len is ADDR_W+1 bits).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a scan; sampled only in IDLE.
- base_addr  input  ADDR_W  first word address; sampled with start.
- len  input  ADDR_W+1  number of words to scan (0 to 2^ADDR_W); sampled with start.
- busy  output  1  high in REQ and WAIT states.
- done  output  1  one-cycle pulse when results are valid.
- all_zero  output  1  every scanned word == 0; held until the next accepted start.
- all_one  output  1  every scanned word has all bits set; held until the next accepted start.
- rd_req  output  1  one-cycle read request.
- rd_addr  output  ADDR_W  read address; valid while rd_req is high.
- rd_data  input  WIDTH  read data; valid with rd_valid.
- rd_valid  input  1  read data strobe; arrives L>=1 cycles after rd_req.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, rd_req, all_zero, all_one = 0; rd_addr and counter = 0. Reset mid-scan abandons the scan; any later rd_valid is ignored because the controller is in IDLE.
- IDLE: on start=1, latch base_addr and len, set z_acc=1, o_acc=1, cnt=0.
  - If len==0: go to DONE. Results are vacuously all_zero=1, all_one=1.
  - Otherwise: go to REQ.
- REQ: rd_req=1 for exactly one cycle, rd_addr=base+cnt (mod 2^ADDR_W, so the address wraps). Next state is WAIT.
- WAIT: hold until rd_valid. On rd_valid:
  - z_acc &= (rd_data==0); o_acc &= (&rd_data); cnt++.
  - If cnt (post-increment) == len, go to DONE. Otherwise go to REQ.
- rd_valid outside WAIT is ignored.
- DONE: done=1 for one cycle; all_zero/all_one are driven from z_acc/o_acc and hold until the next accepted start. Next state is IDLE.
- start while not IDLE is ignored, including start in the same cycle as done.
- Timing: start sampled at edge 0; done asserted in cycle N*(L+1)+1, where N=len and L=read latency. For len=0, done is asserted in cycle 1.
- all_zero and all_one both equal 1 only for len==0 (with WIDTH>0).
- Only one outstanding read at a time; rd_req never asserts in two consecutive cycles.

Optional Feature:
- Macro: ALLBIT_SCAN_EARLY_EXIT_EN.
- Defined: in WAIT, if after the update z_acc==0 and o_acc==0, go to DONE immediately, even if cnt<len. Remaining words are not read.
- Not defined: the full len words are always read, regardless of the flags.
- Result flags are identical in both builds; only timing and read count differ.

Decomposition:
- Package allbit_pkg holds:
  - state enum {IDLE, REQ, WAIT, DONE};
  - default WIDTH and ADDR_W localparams.
- Sub-module allbit_detect (WIDTH-parameterised, combinational): zero = ~|x, one = &x. It is instantiated once, on rd_data.
- The FSM, counter and accumulators stay in the top module.

Test Plan:
- Reset mid-scan: len=8, assert rst_n=0 after the 3rd rd_valid -> all outputs 0 immediately; a late rd_valid is ignored; next start with len=1 on data 0 -> all_zero=1, all_one=0.
- Zero region: base=0x10, len=4, all data 0x00000000, L=2 -> rd_addr 0x10..0x13; done at cycle 13; all_zero=1, all_one=0.
- Ones region with wrap: base=0xFE, len=3, data 0xFFFFFFFF, L=1 -> rd_addr 0xFE, 0xFF, 0x00; all_one=1, all_zero=0; done at cycle 7.
- len=0 -> done at cycle 1, no rd_req, all_zero=1, all_one=1.
- Mixed data: len=4, data {0, 0x12345678, 0, 0xFFFFFFFF}.
  - Without the macro: 4 reads, both flags 0.
  - With ALLBIT_SCAN_EARLY_EXIT_EN: 2 reads, done the cycle after the 2nd rd_valid, both flags 0.
- start asserted during busy and coincident with done -> ignored; latched len/base unchanged; exactly one done per accepted start.
